// File: rtl/instr_fetch.sv
// Instruction fetch unit for the 9-bit CPU.
// Drives the PC into the combinational imem and registers the returned word
// into InstOut. Handles start, stall, taken branches, halt detection and a
// saturating count of delivered instructions. All outputs are registered.
module instr_fetch #(
    parameter int unsigned              PC_W       = 8,
    parameter int unsigned              INST_W     = 9,
    parameter logic [PC_W-1:0]          START_ADDR = '0,
    parameter logic [INST_W-1:0]        HALT_WORD  = '1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Stall,
    input  logic                BranchEn,
    input  logic [PC_W-1:0]     BranchTarget,
    input  logic [INST_W-1:0]   Inst,
    output logic [PC_W-1:0]     PC,
    output logic [INST_W-1:0]   InstOut,
    output logic                InstValid,
    output logic                Halted,
    output logic [15:0]         InstCount
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INST_W-1:0]  inst_q, inst_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic [15:0]        count_q, count_d;

    // Next-state logic: everything holds unless the current state acts.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                end
            end
            S_RUN: begin
                if (!Stall) begin
                    if (BranchEn) begin
                        // Squash the sequential word; a halt word here is discarded too.
                        pc_d    = BranchTarget;
                        valid_d = 1'b0;
                    end else if (Inst == HALT_WORD) begin
                        inst_d   = Inst;
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        inst_d  = Inst;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 1'b1;
                        if (count_q != 16'hFFFF) begin
                            count_d = count_q + 16'd1;
                        end
                    end
                end
            end
            S_HALT: begin
                if (Start) begin
                    state_d  = S_RUN;
                    pc_d     = START_ADDR;
                    halted_d = 1'b0;
                    count_d  = '0;
                    valid_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            pc_q     <= START_ADDR;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign PC        = pc_q;
    assign InstOut   = inst_q;
    assign InstValid = valid_q;
    assign Halted    = halted_q;
    assign InstCount = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: sequential fetch, stall, branch,
// PC wrap (second instance with START_ADDR=254), mid-run reset and restart.
module tb_instr_fetch;

    logic        Clk = 1'b0;
    logic        Reset, Start, Stall, BranchEn;
    logic [7:0]  BranchTarget;

    logic [8:0]  mem   [256];
    logic [8:0]  mem_w [256];

    logic [7:0]  PC, PC_w;
    logic [8:0]  Inst, Inst_w, InstOut, InstOut_w;
    logic        InstValid, InstValid_w, Halted, Halted_w;
    logic [15:0] InstCount, InstCount_w;

    int compared   = 0;
    int mismatched = 0;

    always #5 Clk = ~Clk;

    assign Inst   = mem[PC];
    assign Inst_w = mem_w[PC_w];

    instr_fetch dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .BranchTarget(BranchTarget), .Inst(Inst),
        .PC(PC), .InstOut(InstOut), .InstValid(InstValid),
        .Halted(Halted), .InstCount(InstCount)
    );

    instr_fetch #(.START_ADDR(8'd254)) dut_w (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .BranchTarget(BranchTarget), .Inst(Inst_w),
        .PC(PC_w), .InstOut(InstOut_w), .InstValid(InstValid_w),
        .Halted(Halted_w), .InstCount(InstCount_w)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 9'h000;
            mem_w[i] = 9'h000;
        end
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = 9'h1FF;
    endtask

    task automatic do_reset();
        Reset = 1'b1; tick(); Reset = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1; tick(); Start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if (PC !== 8'd0 || InstOut !== 9'h000 || InstValid !== 1'b0 ||
            Halted !== 1'b0 || InstCount !== 16'd0) begin
            $display("FAIL reset_state: PC=%0d InstOut=%h V=%b H=%b Cnt=%0d, expected 0/000/0/0/0",
                     PC, InstOut, InstValid, Halted, InstCount);
            mismatched++;
        end
        Stall = 1'b1; BranchEn = 1'b1; BranchTarget = 8'd9;
        tick(); tick();
        Stall = 1'b0; BranchEn = 1'b0;
        compared++;
        if (PC !== 8'd0 || InstValid !== 1'b0 || InstCount !== 16'd0) begin
            $display("FAIL idle_hold: PC=%0d V=%b Cnt=%0d, expected 0/0/0", PC, InstValid, InstCount);
            mismatched++;
        end
    endtask

    task automatic test_sequence();
        logic [8:0] exp_seq [3];
        exp_seq[0] = 9'h001; exp_seq[1] = 9'h002; exp_seq[2] = 9'h003;
        load_basic();
        do_reset();
        do_start();
        compared++;
        if (PC !== 8'd0 || InstValid !== 1'b0) begin
            $display("FAIL start_latency: PC=%0d V=%b, expected 0/0", PC, InstValid);
            mismatched++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (InstOut !== exp_seq[i] || InstValid !== 1'b1 || PC !== 8'(i + 1) ||
                InstCount !== 16'(i + 1)) begin
                $display("FAIL seq_%0d: InstOut=%h V=%b PC=%0d Cnt=%0d, expected %h/1/%0d/%0d",
                         i, InstOut, InstValid, PC, InstCount, exp_seq[i], i + 1, i + 1);
                mismatched++;
            end
        end
        tick();
        compared++;
        if (Halted !== 1'b1 || PC !== 8'd3 || InstCount !== 16'd3 || InstValid !== 1'b0 ||
            InstOut !== 9'h1FF) begin
            $display("FAIL seq_halt: H=%b PC=%0d Cnt=%0d V=%b InstOut=%h, expected 1/3/3/0/1ff",
                     Halted, PC, InstCount, InstValid, InstOut);
            mismatched++;
        end
        tick();
        compared++;
        if (Halted !== 1'b1 || PC !== 8'd3 || InstCount !== 16'd3) begin
            $display("FAIL halt_hold: H=%b PC=%0d Cnt=%0d, expected 1/3/3", Halted, PC, InstCount);
            mismatched++;
        end
    endtask

    task automatic test_stall();
        load_basic();
        do_reset();
        do_start();
        tick(); tick();
        compared++;
        if (InstOut !== 9'h002 || PC !== 8'd2) begin
            $display("FAIL stall_pre: InstOut=%h PC=%0d, expected 002/2", InstOut, PC);
            mismatched++;
        end
        // Branch request during stall must be ignored.
        Stall = 1'b1; BranchEn = 1'b1; BranchTarget = 8'd10;
        for (int i = 0; i < 2; i++) begin
            tick();
            compared++;
            if (InstOut !== 9'h002 || PC !== 8'd2 || InstCount !== 16'd2 || InstValid !== 1'b1) begin
                $display("FAIL stall_hold_%0d: InstOut=%h PC=%0d Cnt=%0d V=%b, expected 002/2/2/1",
                         i, InstOut, PC, InstCount, InstValid);
                mismatched++;
            end
        end
        Stall = 1'b0; BranchEn = 1'b0;
        tick();
        compared++;
        if (InstOut !== 9'h003 || PC !== 8'd3 || InstCount !== 16'd3) begin
            $display("FAIL stall_resume: InstOut=%h PC=%0d Cnt=%0d, expected 003/3/3", InstOut, PC, InstCount);
            mismatched++;
        end
        tick();
        compared++;
        if (Halted !== 1'b1 || InstCount !== 16'd3) begin
            $display("FAIL stall_halt: H=%b Cnt=%0d, expected 1/3", Halted, InstCount);
            mismatched++;
        end
    endtask

    task automatic test_branch();
        clear_mem();
        mem[0] = 9'h0AA; mem[1] = 9'h1FF; mem[10] = 9'h0BB; mem[11] = 9'h1FF;
        do_reset();
        do_start();
        tick();
        compared++;
        if (InstOut !== 9'h0AA || InstValid !== 1'b1 || PC !== 8'd1) begin
            $display("FAIL br_pre: InstOut=%h V=%b PC=%0d, expected 0aa/1/1", InstOut, InstValid, PC);
            mismatched++;
        end
        BranchEn = 1'b1; BranchTarget = 8'd10;
        tick();
        BranchEn = 1'b0;
        compared++;
        if (InstValid !== 1'b0 || PC !== 8'd10 || InstOut !== 9'h0AA || Halted !== 1'b0) begin
            $display("FAIL br_bubble: V=%b PC=%0d InstOut=%h H=%b, expected 0/10/0aa/0",
                     InstValid, PC, InstOut, Halted);
            mismatched++;
        end
        tick();
        compared++;
        if (InstOut !== 9'h0BB || InstValid !== 1'b1 || PC !== 8'd11 || InstCount !== 16'd2) begin
            $display("FAIL br_target: InstOut=%h V=%b PC=%0d Cnt=%0d, expected 0bb/1/11/2",
                     InstOut, InstValid, PC, InstCount);
            mismatched++;
        end
        tick();
        compared++;
        if (Halted !== 1'b1 || PC !== 8'd11 || InstCount !== 16'd2) begin
            $display("FAIL br_halt: H=%b PC=%0d Cnt=%0d, expected 1/11/2", Halted, PC, InstCount);
            mismatched++;
        end
    endtask

    task automatic test_wrap();
        clear_mem();
        mem_w[254] = 9'h010; mem_w[255] = 9'h011; mem_w[0] = 9'h1FF;
        do_reset();
        compared++;
        if (PC_w !== 8'd254) begin
            $display("FAIL wrap_reset_pc: PC=%0d, expected 254", PC_w);
            mismatched++;
        end
        do_start();
        tick();
        compared++;
        if (InstOut_w !== 9'h010 || PC_w !== 8'd255) begin
            $display("FAIL wrap_254: InstOut=%h PC=%0d, expected 010/255", InstOut_w, PC_w);
            mismatched++;
        end
        tick();
        compared++;
        if (InstOut_w !== 9'h011 || PC_w !== 8'd0) begin
            $display("FAIL wrap_255: InstOut=%h PC=%0d, expected 011/0", InstOut_w, PC_w);
            mismatched++;
        end
        tick();
        compared++;
        if (Halted_w !== 1'b1 || PC_w !== 8'd0 || InstCount_w !== 16'd2) begin
            $display("FAIL wrap_halt: H=%b PC=%0d Cnt=%0d, expected 1/0/2", Halted_w, PC_w, InstCount_w);
            mismatched++;
        end
    endtask

    task automatic test_reset_midrun();
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = 9'(i + 1);
        mem[8] = 9'h1FF;
        do_reset();
        do_start();
        for (int i = 0; i < 5; i++) tick();
        compared++;
        if (InstCount !== 16'd5 || PC !== 8'd5 || InstOut !== 9'h005) begin
            $display("FAIL mid_pre: Cnt=%0d PC=%0d InstOut=%h, expected 5/5/005", InstCount, PC, InstOut);
            mismatched++;
        end
        do_reset();
        compared++;
        if (PC !== 8'd0 || InstValid !== 1'b0 || InstCount !== 16'd0 || InstOut !== 9'h000 ||
            Halted !== 1'b0) begin
            $display("FAIL mid_reset: PC=%0d V=%b Cnt=%0d InstOut=%h H=%b, expected 0/0/0/000/0",
                     PC, InstValid, InstCount, InstOut, Halted);
            mismatched++;
        end
        for (int i = 0; i < 3; i++) tick();
        compared++;
        if (PC !== 8'd0 || InstValid !== 1'b0 || InstCount !== 16'd0) begin
            $display("FAIL mid_idle: PC=%0d V=%b Cnt=%0d, expected 0/0/0", PC, InstValid, InstCount);
            mismatched++;
        end
    endtask

    task automatic test_restart();
        load_basic();
        do_reset();
        do_start();
        for (int i = 0; i < 4; i++) tick();
        compared++;
        if (Halted !== 1'b1 || InstCount !== 16'd3) begin
            $display("FAIL rs_first_halt: H=%b Cnt=%0d, expected 1/3", Halted, InstCount);
            mismatched++;
        end
        do_start();
        compared++;
        if (Halted !== 1'b0 || InstCount !== 16'd0 || PC !== 8'd0 || InstValid !== 1'b0) begin
            $display("FAIL rs_restart: H=%b Cnt=%0d PC=%0d V=%b, expected 0/0/0/0",
                     Halted, InstCount, PC, InstValid);
            mismatched++;
        end
        tick();
        // Start while running must not reload the PC.
        do_start();
        compared++;
        if (PC !== 8'd2 || InstOut !== 9'h002 || InstCount !== 16'd2) begin
            $display("FAIL rs_start_in_run: PC=%0d InstOut=%h Cnt=%0d, expected 2/002/2", PC, InstOut, InstCount);
            mismatched++;
        end
        tick(); tick();
        compared++;
        if (Halted !== 1'b1 || InstCount !== 16'd3 || PC !== 8'd3) begin
            $display("FAIL rs_second_halt: H=%b Cnt=%0d PC=%0d, expected 1/3/3", Halted, InstCount, PC);
            mismatched++;
        end
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0; BranchTarget = 8'd0;
        clear_mem();
        tick();
        test_reset();
        test_sequence();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_midrun();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
